lsu: RTL

//  Memory stage directly downstream of the ALU. Takes the ALU result plus rs2 data from EX.
//  - Non-memory ops: passes the ALU result through to writeback.
//  - Loads/stores: uses the ALU result as the byte address. Runs one request/response

---
 rtl/lsu_pkg.sv | 38 +++
 rtl/lsu_load_align.sv | 29 ++
 rtl/lsu.sv | 139 +++++++++++++
 3 files changed

// File: rtl/lsu_pkg.sv
// Shared definitions for the load/store unit: RV32I funct3 width codes,
// FSM state encoding, and the ld/st legality check.
package lsu_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_RSP  = 2'd2
  } state_e;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  typedef struct packed {
    logic [3:0]  strb;
    logic [31:0] data;
  } st_lane_t;

  // Unsigned variants exist only for loads; halves need addr[0]=0, words addr[1:0]=0.
  function automatic logic ls_legal(input logic ld, input logic [2:0] f3,
                                    input logic [1:0] a);
    logic ok;
    ok = 1'b0;
    case (f3)
      F3_B:  ok = 1'b1;
      F3_H:  ok = !a[0];
      F3_W:  ok = (a == 2'b00);
      F3_BU: ok = ld;
      F3_HU: ok = ld & !a[0];
      default: ok = 1'b0;
    endcase
    return ok;
  endfunction

endpackage

// File: rtl/lsu_load_align.sv
// Selects the addressed byte/half/word lane of a read word and sign- or
// zero-extends it according to the load funct3.
module lsu_load_align
  import lsu_pkg::*;
(
  input  logic [1:0]  addr,
  input  logic [2:0]  funct3,
  input  logic [31:0] rdata,
  output logic [31:0] data
);

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  always_comb begin
    byte_sel = rdata[8*addr +: 8];
    half_sel = addr[1] ? rdata[31:16] : rdata[15:0];
    data     = 32'd0;
    case (funct3)
      F3_B:  data = {{24{byte_sel[7]}}, byte_sel};
      F3_H:  data = {{16{half_sel[15]}}, half_sel};
      F3_W:  data = rdata;
      F3_BU: data = {24'd0, byte_sel};
      F3_HU: data = {16'd0, half_sel};
      default: data = 32'd0;
    endcase
  end

endmodule

// File: rtl/lsu.sv
// Memory stage: passes ALU results through, or runs one request/response
// memory transaction per load/store and presents the result to writeback.
module lsu
  import lsu_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            ex_valid,
  output logic            ex_ready,
  input  logic [XLEN-1:0] ex_result,
  input  logic [XLEN-1:0] ex_wdata,
  input  logic            ex_ld,
  input  logic            ex_st,
  input  logic [2:0]      ex_funct3,
  input  logic [4:0]      ex_rd,
  output logic            mem_req,
  output logic            mem_we,
  output logic [XLEN-1:0] mem_addr,
  output logic [3:0]      mem_wstrb,
  output logic [XLEN-1:0] mem_wdata,
  input  logic            mem_gnt,
  input  logic            mem_rvalid,
  input  logic [XLEN-1:0] mem_rdata,
  output logic            wb_valid,
  input  logic            wb_ready,
  output logic [XLEN-1:0] wb_data,
  output logic [4:0]      wb_rd,
  output logic            wb_exc
);

  state_e      state_q, state_d;
  logic        accept, is_mem, legal, launch, done;
  logic [2:0]  f3_q;
  logic [1:0]  a_lo_q;
  logic [4:0]  rd_q;
  logic        ld_q;
  logic [31:0] ld_data;
  st_lane_t    st_lane;

  function automatic st_lane_t store_fmt(input logic [2:0] f3, input logic [1:0] a,
                                         input logic [31:0] wd);
    st_lane_t r;
    r.strb = 4'b0000;
    r.data = 32'd0;
    case (f3)
      F3_B: begin r.strb = 4'b0001 << a;                     r.data = {4{wd[7:0]}};  end
      F3_H: begin r.strb = a[1] ? 4'b1100 : 4'b0011;         r.data = {2{wd[15:0]}}; end
      F3_W: begin r.strb = 4'b1111;                          r.data = wd;            end
      default: begin r.strb = 4'b0000;                       r.data = 32'd0;         end
    endcase
    return r;
  endfunction

  lsu_load_align u_align (
    .addr   (a_lo_q),
    .funct3 (f3_q),
    .rdata  (mem_rdata),
    .data   (ld_data)
  );

  always_comb begin
    st_lane  = store_fmt(ex_funct3, ex_result[1:0], ex_wdata);
    ex_ready = (state_q == ST_IDLE) & (!wb_valid | wb_ready);
    accept   = ex_valid & ex_ready;
    is_mem   = ex_ld | ex_st;
    legal    = ls_legal(ex_ld, ex_funct3, ex_result[1:0]);
    launch   = accept & is_mem & legal;
    done     = (state_q == ST_RSP) & mem_rvalid;
    mem_req  = 1'b0;
    state_d  = state_q;
    case (state_q)
      ST_IDLE: if (launch) state_d = ST_REQ;
      ST_REQ: begin
        mem_req = 1'b1;
        if (mem_gnt) state_d = ST_RSP;
      end
      ST_RSP:  if (mem_rvalid) state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= ST_IDLE;
    else     state_q <= state_d;
  end

  // Request register: latched once at launch, stable through REQ until grant.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mem_addr  <= '0;
      mem_we    <= 1'b0;
      mem_wstrb <= 4'b0000;
      mem_wdata <= '0;
      f3_q      <= 3'd0;
      a_lo_q    <= 2'd0;
      rd_q      <= 5'd0;
      ld_q      <= 1'b0;
    end else if (launch) begin
      mem_addr  <= {ex_result[31:2], 2'b00};
      mem_we    <= ex_st;
      mem_wstrb <= ex_st ? st_lane.strb : 4'b0000;
      mem_wdata <= ex_st ? st_lane.data : 32'd0;
      f3_q      <= ex_funct3;
      a_lo_q    <= ex_result[1:0];
      rd_q      <= ex_rd;
      ld_q      <= ex_ld;
    end
  end

  // Writeback slot: an accept in the same cycle as a drain overwrites it directly.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wb_valid <= 1'b0;
      wb_data  <= '0;
      wb_rd    <= 5'd0;
      wb_exc   <= 1'b0;
    end else if (accept && !is_mem) begin
      wb_valid <= 1'b1;
      wb_data  <= ex_result;
      wb_rd    <= ex_rd;
      wb_exc   <= 1'b0;
    end else if (accept && !legal) begin
      wb_valid <= 1'b1;
      wb_data  <= '0;
      wb_rd    <= ex_rd;
      wb_exc   <= 1'b1;
    end else if (done) begin
      wb_valid <= 1'b1;
      wb_data  <= ld_q ? ld_data : 32'd0;
      wb_rd    <= rd_q;
      wb_exc   <= 1'b0;
    end else if (wb_ready) begin
      wb_valid <= 1'b0;
    end
  end

endmodule
